// File: rtl/ddr_refresh_ctrl_pkg.sv
// ddr_refresh_ctrl_pkg
//   Shared definitions for the DDR refresh scheduler:
//   - SDRAM command encodings {ras_n,cas_n,we_n}
//   - refresh FSM state encoding
//   - the command-bus drive bundle
//   - a small max helper used when sizing the wait timer
package ddr_refresh_ctrl_pkg;

  localparam logic [2:0] DDR_CMD_NOP          = 3'b111;
  localparam logic [2:0] DDR_CMD_PRECHARGE    = 3'b010;
  localparam logic [2:0] DDR_CMD_AUTO_REFRESH = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_PRE,
    ST_WAIT_RP,
    ST_AREF,
    ST_WAIT_RFC,
    ST_DONE
  } ref_state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] cmd;
    logic       a10;
  } sdram_cmd_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr_refresh_ctrl.sv
// ddr_refresh_ctrl
//   Refresh scheduler. Counts 7.8us ticks into a deferred-refresh counter,
//   requests the SDRAM command bus, and on grant issues PRECHARGE-ALL then
//   AUTO-REFRESH, spaced by tRP and tRFC.
// Ports
//   clk, reset        clock; synchronous active-low reset
//   pulse78           one-cycle refresh tick
//   enable            0 blocks new requests (ticks still counted)
//   ref_req/ref_gnt   command-bus request / level grant
//   ref_urgent        pending >= urgent_thresh
//   ref_busy          PRE..WAIT_RFC in progress
//   cmd_valid/cmd/cmd_a10  SDRAM command drive
//   ref_done          one-cycle completion pulse
//   pending           deferred-refresh count
//   ref_overflow      sticky: tick lost at the postpone ceiling
module ddr_refresh_ctrl
  import ddr_refresh_ctrl_pkg::*;
#(
  parameter int trp_cycles    = 3,
  parameter int trfc_cycles   = 4,
  parameter int max_postpone  = 8,
  parameter int urgent_thresh = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse78,
  input  logic       enable,
  output logic       ref_req,
  output logic       ref_urgent,
  input  logic       ref_gnt,
  output logic       ref_busy,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic       cmd_a10,
  output logic       ref_done,
  output logic [3:0] pending,
  output logic       ref_overflow
);

  localparam int             TW      = $clog2(max2(trp_cycles, trfc_cycles)) + 1;
  localparam logic [TW-1:0]  TRP_LD  = TW'(trp_cycles - 1);
  localparam logic [TW-1:0]  TRFC_LD = TW'(trfc_cycles - 1);
  localparam logic [3:0]     PMAX    = 4'(max_postpone);
  localparam logic [3:0]     PURG    = 4'(urgent_thresh);

  ref_state_e    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  sdram_cmd_t    sc;
  logic          inc, dec;

  assign inc = pulse78 && (pending < PMAX);
  assign dec = (state == ST_AREF) && (pending != 4'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      timer        <= '0;
      pending      <= '0;
      ref_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (inc && !dec)      pending <= pending + 4'd1;
      else if (dec && !inc) pending <= pending - 4'd1;
      if (pulse78 && (pending >= PMAX)) ref_overflow <= 1'b1;
    end
  end

  // Timer holds the number of wait cycles still to run after PRE/AREF;
  // the wait state that sees 1 is the last one, so PRE->AREF is exactly
  // trp_cycles clocks and AREF->DONE exactly trfc_cycles clocks.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    sc        = '{valid: 1'b0, cmd: DDR_CMD_NOP, a10: 1'b0};
    ref_busy  = 1'b0;
    ref_done  = 1'b0;
    case (state)
      ST_IDLE: if (enable && (pending != 4'd0)) state_nxt = ST_REQ;
      ST_REQ:  if (ref_gnt) state_nxt = ST_PRE;
      ST_PRE: begin
        sc       = '{valid: 1'b1, cmd: DDR_CMD_PRECHARGE, a10: 1'b1};
        ref_busy = 1'b1;
        if (trp_cycles == 1) state_nxt = ST_AREF;
        else begin
          timer_nxt = TRP_LD;
          state_nxt = ST_WAIT_RP;
        end
      end
      ST_WAIT_RP: begin
        ref_busy = 1'b1;
        if (timer > TW'(1)) timer_nxt = timer - TW'(1);
        else begin
          timer_nxt = '0;
          state_nxt = ST_AREF;
        end
      end
      ST_AREF: begin
        sc       = '{valid: 1'b1, cmd: DDR_CMD_AUTO_REFRESH, a10: 1'b0};
        ref_busy = 1'b1;
        if (trfc_cycles == 1) state_nxt = ST_DONE;
        else begin
          timer_nxt = TRFC_LD;
          state_nxt = ST_WAIT_RFC;
        end
      end
      ST_WAIT_RFC: begin
        ref_busy = 1'b1;
        if (timer > TW'(1)) timer_nxt = timer - TW'(1);
        else begin
          timer_nxt = '0;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        ref_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ref_req    = ref_busy || (state == ST_REQ);
  assign ref_urgent = (pending >= PURG);
  assign cmd_valid  = sc.valid;
  assign cmd        = sc.cmd;
  assign cmd_a10    = sc.a10;

endmodule

// File: tb/tb_ddr_refresh_ctrl.sv
// tb_ddr_refresh_ctrl
//   Self-checking bench: table-driven vectors for the basic grant sequence,
//   hand sequences for reset/saturation/enable/grant-delay corners, and
//   randomized traffic compared every cycle against a phase-offset model.
module tb_ddr_refresh_ctrl;

  localparam int TRP  = 3;
  localparam int TRFC = 4;
  localparam int PMAX = 8;
  localparam int UTH  = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0, pulse78 = 1'b0, enable = 1'b0, ref_gnt = 1'b0;
  logic       ref_req, ref_urgent, ref_busy, cmd_valid, cmd_a10, ref_done, ref_overflow;
  logic [2:0] cmd;
  logic [3:0] pending;

  always #5 clk = ~clk;

  ddr_refresh_ctrl #(
    .trp_cycles(TRP), .trfc_cycles(TRFC), .max_postpone(PMAX), .urgent_thresh(UTH)
  ) dut (
    .clk(clk), .reset(reset), .pulse78(pulse78), .enable(enable),
    .ref_req(ref_req), .ref_urgent(ref_urgent), .ref_gnt(ref_gnt),
    .ref_busy(ref_busy), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_a10(cmd_a10),
    .ref_done(ref_done), .pending(pending), .ref_overflow(ref_overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending count plus the cycle offset since PRE.
  int m_pending;
  bit m_ovf;
  bit m_req;
  int m_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [13:0] dut_out();
    return {pending, ref_req, ref_urgent, ref_busy, cmd_valid, cmd, cmd_a10, ref_done, ref_overflow};
  endfunction

  function automatic logic [13:0] model_out();
    bit busy, pre, aref, done;
    logic [2:0] c;
    busy = (m_idx >= 0) && (m_idx < TRP + TRFC);
    pre  = (m_idx == 0);
    aref = (m_idx == TRP);
    done = (m_idx == TRP + TRFC);
    c    = pre ? 3'b010 : (aref ? 3'b001 : 3'b111);
    return {4'(m_pending), m_req || busy, m_pending >= UTH, busy, pre || aref, c, pre, done, m_ovf};
  endfunction

  task automatic model_step(input bit rst, input bit p, input bit en, input bit g);
    bit aref;
    int pend0;
    if (!rst) begin
      m_pending = 0; m_ovf = 0; m_req = 0; m_idx = -1;
      return;
    end
    aref  = (m_idx == TRP);
    pend0 = m_pending;
    if (p && pend0 == PMAX) m_ovf = 1;
    m_pending = pend0 + ((p && pend0 < PMAX) ? 1 : 0) - ((aref && pend0 > 0) ? 1 : 0);
    if (m_idx >= 0)  m_idx = (m_idx == TRP + TRFC) ? -1 : m_idx + 1;
    else if (m_req) begin
      if (g) begin m_idx = 0; m_req = 0; end
    end else if (en && pend0 != 0) m_req = 1;
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1ns later.
  task automatic cyc(input bit rst, input bit p, input bit en, input bit g);
    reset = rst; pulse78 = p; enable = en; ref_gnt = g;
    @(posedge clk);
    model_step(rst, p, en, g);
    #1;
    check("model", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  typedef struct {
    bit         p;
    bit         g;
    logic [3:0] pend;
    bit         req;
    bit         busy;
    logic [2:0] cmd;
    bit         done;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int k, bad, rises, dones;
    bit prev_req;

    tbl[0]  = '{1, 1, 4'd1, 0, 0, 3'b111, 0};
    tbl[1]  = '{0, 1, 4'd1, 1, 0, 3'b111, 0};
    tbl[2]  = '{0, 1, 4'd1, 1, 1, 3'b010, 0};
    tbl[3]  = '{0, 1, 4'd1, 1, 1, 3'b111, 0};
    tbl[4]  = '{0, 1, 4'd1, 1, 1, 3'b111, 0};
    tbl[5]  = '{0, 1, 4'd1, 1, 1, 3'b001, 0};
    tbl[6]  = '{0, 1, 4'd0, 1, 1, 3'b111, 0};
    tbl[7]  = '{0, 1, 4'd0, 1, 1, 3'b111, 0};
    tbl[8]  = '{0, 1, 4'd0, 1, 1, 3'b111, 0};
    tbl[9]  = '{0, 1, 4'd0, 0, 0, 3'b111, 1};
    tbl[10] = '{0, 1, 4'd0, 0, 0, 3'b111, 0};

    // Reset state
    do_reset();
    check("reset_state", 32'(dut_out()), 32'({4'd0, 4'b0000, 3'b111, 3'b000}));

    // Single refresh with grant tied high
    for (int i = 0; i < 11; i++) begin
      cyc(1, tbl[i].p, 1, tbl[i].g);
      check($sformatf("vec%0d", i), 32'({pending, ref_req, ref_busy, cmd, ref_done}),
            32'({tbl[i].pend, tbl[i].req, tbl[i].busy, tbl[i].cmd, tbl[i].done}));
    end

    // Reset mid-WAIT_RFC aborts without ref_done
    for (int i = 0; i < 7; i++) cyc(1, tbl[i].p, 1, 1);
    check("in_wait_rfc", 32'({ref_busy, pending}), 32'({1'b1, 4'd0}));
    do_reset();
    check("abort_state", 32'({pending, ref_req, ref_busy, cmd_valid, cmd, ref_done}),
          32'({4'd0, 4'b0000, 3'b111, 1'b0}));
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 1, 1);
      if (ref_done) bad++;
    end
    check("no_done_after_abort", 32'(bad), 32'(0));

    // Saturation, overflow and urgency with no grant
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      cyc(1, 1, 1, 0);
      k = (i > 8) ? 8 : i;
      check($sformatf("sat%0d", i), 32'({pending, ref_urgent, ref_overflow}),
            32'({4'(k), k >= 6, i == 9}));
    end
    cyc(1, 0, 1, 0);
    check("sat_req_held", 32'({ref_req, ref_overflow, pending}), 32'({2'b11, 4'd8}));

    // Tick coinciding with AREF leaves pending unchanged
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0);
    k = 0;
    while (!(cmd_valid && cmd == 3'b001) && k < 20) begin
      cyc(1, 0, 1, 1);
      k++;
    end
    check("aref_reached", 32'(k < 20), 32'(1));
    check("pend_at_aref", 32'(pending), 32'(3));
    cyc(1, 1, 1, 0);
    check("pend_inc_dec", 32'(pending), 32'(3));

    // Disabled counting, then two back-to-back sequences with a gap
    do_reset();
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    check("dis_pend_req", 32'({pending, ref_req}), 32'({4'd2, 1'b0}));
    rises = 0; dones = 0; prev_req = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, 1, 1);
      if (ref_req && !prev_req) rises++;
      if (ref_done) dones++;
      prev_req = ref_req;
    end
    check("two_req_rises", 32'(rises), 32'(2));
    check("two_dones", 32'({4'(dones), pending}), 32'({4'd2, 4'd0}));

    // Grant held off for 20 cycles
    do_reset();
    cyc(1, 1, 1, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 1, 0);
      if (cmd !== 3'b111 || cmd_valid || ref_busy || !ref_req) bad++;
    end
    check("gnt_delay_hold", 32'(bad), 32'(0));
    cyc(1, 0, 1, 1);
    check("gnt_delay_pre", 32'({cmd_valid, cmd, cmd_a10, ref_busy}), 32'({1'b1, 3'b010, 2'b11}));

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 299) != 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
